// File: rtl/board_pkg.sv
// Shared defaults, clear-FSM state type and row helpers for the Tetris board store.
package board_pkg;

    localparam int ROWS_DEF = 20;
    localparam int COLS_DEF = 10;

    // Widest row row_is_full() can inspect; callers zero-extend narrower rows.
    localparam int MAX_COLS = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FILL,
        ST_DONE
    } clr_state_e;

    function automatic logic row_is_full(input logic [MAX_COLS-1:0] row, input int cols);
        logic full;
        full = (cols > 0);
        for (int i = 0; i < MAX_COLS; i++) begin
            if ((i < cols) && !row[i]) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/board_clear_ctrl.sv
// Line-clear sequencer: walks source rows bottom-up, tells the board which row to move
// or zero, and reports how many full rows were dropped.
module board_clear_ctrl
    import board_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int IDX_W = $clog2(ROWS),
    parameter int CNT_W = $clog2(ROWS + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_req_i,
    input  logic             clr_req_i,
    input  logic             src_full_i,
    output logic             ready_o,
    output logic             move_o,
    output logic             zero_o,
    output logic [IDX_W-1:0] src_idx_o,
    output logic [IDX_W-1:0] dst_idx_o,
    output logic             clr_done_o,
    output logic [CNT_W-1:0] lines_cleared_o
);

    localparam logic [IDX_W:0]   LAST_ROW = (IDX_W + 1)'(ROWS - 1);
    localparam logic [IDX_W:0]   IDX_ONE  = (IDX_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    clr_state_e       state_q, state_d;
    logic [IDX_W:0]   src_q, src_d;
    logic [IDX_W:0]   dst_q, dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lines_q, lines_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            src_q   <= LAST_ROW;
            dst_q   <= LAST_ROW;
            cnt_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        move_o  = 1'b0;
        zero_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A simultaneous write takes priority; the clear request is simply dropped.
                if (clr_req_i && !wr_req_i) begin
                    state_d = ST_SCAN;
                    src_d   = LAST_ROW;
                    dst_d   = LAST_ROW;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (src_full_i) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    move_o = (dst_q != src_q);
                    dst_d  = dst_q - IDX_ONE;
                end
                src_d = src_q - IDX_ONE;
                if (src_q == '0) begin
                    state_d = (cnt_d != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                zero_o = 1'b1;
                dst_d  = dst_q - IDX_ONE;
                if (dst_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Publish the count as the pass enters DONE so it is valid alongside clr_done.
        if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
            lines_d = cnt_d;
        end
    end

    assign ready_o         = (state_q == ST_IDLE);
    assign clr_done_o      = (state_q == ST_DONE);
    assign src_idx_o       = src_q[IDX_W-1:0];
    assign dst_idx_o       = dst_q[IDX_W-1:0];
    assign lines_cleared_o = lines_q;

endmodule

// File: rtl/board_store.sv
// ROWS x COLS occupancy board with handshaked row writes, a combinational row read
// port and a multi-cycle line-clear pass.
module board_store
    import board_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int IDX_W = $clog2(ROWS),
    parameter int CNT_W = $clog2(ROWS + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wr_req_i,
    input  logic [IDX_W-1:0]     wr_row_idx_i,
    input  logic [COLS-1:0]      wr_row_data_i,
    input  logic                 clr_req_i,
    input  logic [IDX_W-1:0]     rd_row_idx_i,
    output logic [COLS-1:0]      rd_row_data_o,
    output logic                 ready_o,
    output logic                 wr_ack_o,
    output logic                 wr_err_o,
    output logic                 clr_done_o,
    output logic [CNT_W-1:0]     lines_cleared_o,
    output logic [ROWS*COLS-1:0] board_o
);

    localparam logic [IDX_W:0] ROWS_LIM = (IDX_W + 1)'(ROWS);

    logic [COLS-1:0]     rows_q [ROWS];
    logic [COLS-1:0]     rows_d [ROWS];
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;

    logic                ready;
    logic                move;
    logic                zero;
    logic                src_full;
    logic [IDX_W-1:0]    src_idx;
    logic [IDX_W-1:0]    dst_idx;
    logic [MAX_COLS-1:0] src_ext;
    logic                wr_fire;
    logic                wr_valid;
    logic                rd_valid;

    assign wr_fire  = ready && wr_req_i;
    assign wr_valid = ({1'b0, wr_row_idx_i} < ROWS_LIM);
    assign rd_valid = ({1'b0, rd_row_idx_i} < ROWS_LIM);

    always_comb begin
        src_ext             = '0;
        src_ext[COLS-1:0]   = rows_q[src_idx];
        src_full            = row_is_full(src_ext, COLS);
    end

    board_clear_ctrl #(
        .ROWS  (ROWS),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_clear_ctrl (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .wr_req_i        (wr_req_i),
        .clr_req_i       (clr_req_i),
        .src_full_i      (src_full),
        .ready_o         (ready),
        .move_o          (move),
        .zero_o          (zero),
        .src_idx_o       (src_idx),
        .dst_idx_o       (dst_idx),
        .clr_done_o      (clr_done_o),
        .lines_cleared_o (lines_cleared_o)
    );

    // Writes only happen in IDLE and moves/zeroes only during a pass, so these never collide.
    always_comb begin
        rows_d = rows_q;
        if (wr_fire && wr_valid) begin
            rows_d[wr_row_idx_i] = wr_row_data_i;
        end
        if (move) begin
            rows_d[dst_idx] = rows_q[src_idx];
        end
        if (zero) begin
            rows_d[dst_idx] = '0;
        end
        wr_ack_d = wr_fire;
        wr_err_d = wr_fire && !wr_valid;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < ROWS; r++) begin
                rows_q[r] <= '0;
            end
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rows_q   <= rows_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        rd_row_data_o = '0;
        if (rd_valid) begin
            rd_row_data_o = rows_q[rd_row_idx_i];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_flat
        assign board_o[r*COLS +: COLS] = rows_q[r];
    end

    assign ready_o  = ready;
    assign wr_ack_o = wr_ack_q;
    assign wr_err_o = wr_err_q;

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Parametrised successor to the single-port Tetris board register.
- Holds a ROWS x COLS occupancy board and accepts single-row writes through a req/ack handshake.
- Gives a combinational row read port.
- Adds a multi-cycle line-clear engine: it removes every full row, compacts the rows above it downward and reports the count. The game controller uses the count for scoring.

Parameters:
- ROWS, 20, number of board rows; row 0 is top, row ROWS-1 is bottom.
- COLS, 10, cells per row; bit 0 is leftmost, bit COLS-1 is rightmost.
- IDX_W, $clog2(ROWS), row index width. Derived; do not override.
- CNT_W, $clog2(ROWS+1), line-count width. Derived.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  request to write one row; sampled when ready=1.
- wr_row_idx  in  IDX_W  target row of the write.
- wr_row_data  in  COLS  new contents of the target row.
- clr_req  in  1  request to start a line-clear pass; sampled when ready=1.
- rd_row_idx  in  IDX_W  row to read.
- rd_row_data  out  COLS  combinational read of board[rd_row_idx]; 0 when the index is >= ROWS.
- ready  out  1  high when the block is idle and can accept a request.
- wr_ack  out  1  one-cycle pulse after each accepted write.
- wr_err  out  1  pulses together with wr_ack when wr_row_idx >= ROWS. The board is left unchanged in that case.
- clr_done  out  1  one-cycle pulse when a clear pass completes.
- lines_cleared  out  CNT_W  number of rows removed by the last pass; held until the next pass completes.
- board  out  ROWS*COLS  flat board; row r occupies bits [r*COLS +: COLS].

Behaviour:
- Reset: board=0, lines_cleared=0, wr_ack=0, wr_err=0, clr_done=0, ready=1, FSM=IDLE. Reset dominates every other input, including in the middle of a pass. A pass aborted by reset produces no clr_done.
- FSM states: IDLE, SCAN, FILL, DONE.
- IDLE:
  - ready=1.
  - wr_req=1: at the clock edge, write the row if the index is valid. On the next cycle wr_ack=1, plus wr_err if the index was invalid. Stay in IDLE, so back-to-back writes are allowed, one per cycle.
  - clr_req=1 with wr_req=0: go to SCAN with src=ROWS-1, dst=ROWS-1, cnt=0.
  - wr_req and clr_req together: the write wins and clr_req is dropped. The requester must re-assert it.
- SCAN:
  - ready=0; one source row per cycle.
  - If board[src] is all ones, cnt++.
  - Otherwise, if dst!=src, board[dst]<=board[src]; then dst--.
  - src--. After processing src=0, go to FILL if cnt>0, else go to DONE.
- FILL:
  - ready=0; writes zero to row dst each cycle, then dst--.
  - Exactly cnt cycles; ends after row 0 is zeroed, then go to DONE.
- DONE:
  - One cycle with clr_done=1 and lines_cleared<=cnt.
  - ready=0 in this cycle; return to IDLE.
- Latency: from the clr_req accept edge to the clr_done cycle is ROWS + cnt + 1 cycles.
- Requests while ready=0: ignored, with no ack and no queuing.
- Row full test: a row is full when all COLS bits are set. A row of all zeros is never full.
- Counters: src and dst are IDX_W+1 bits wide so the decrement past 0 is detectable without wrap. cnt saturates naturally at ROWS, when every row is full.
- rd_row_data reflects the register state and updates the cycle after any write or shift.

Decomposition:
- Shared package board_pkg holds:
  - the ROWS and COLS defaults;
  - the FSM state enum;
  - a function row_is_full(row).
- One natural sub-module, board_clear_ctrl, containing the FSM, the src/dst/cnt counters and the row-move/zero strobes. The board register array and the read mux stay in the top level.

Test Plan:
1. Reset, then write row 19 = 10'h3FF and row 5 = 10'h0A5 -> wr_ack pulses on each following cycle and rd_row_data(5)=10'h0A5.
2. Write row 25 -> wr_ack=1 and wr_err=1; board unchanged.
3. Fill rows 19 and 17 with 3FF, set row 18=001 and row 16=100, then clr_req -> clr_done 23 cycles later, lines_cleared=2, row 19=001, row 18=100, rows 0-17=0.
4. clr_req on a board with no full rows -> clr_done 21 cycles later, lines_cleared=0, board unchanged.
5. All 20 rows set to 3FF, then clr_req -> lines_cleared=20 and board=0. Also: wr_req together with clr_req -> only the write happens and the FSM stays in IDLE.
6. Assert reset in the 10th SCAN cycle -> board=0, ready=1, no clr_done; a write on the next cycle is accepted.
